// File: rtl/accel_frame_ctrl_pkg.sv
// accel_frame_ctrl_pkg
// Shared definitions for the frame sequencer and its scanout skid buffer:
// FSM state encodings, default geometry, accelerator address window bit
// positions and the word format carried through the skid buffer.
package accel_frame_ctrl_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;  // CPU owns the accelerator port
    localparam logic [1:0] ST_DRAW  = 2'd1;  // accelerator draws the frame
    localparam logic [1:0] ST_SCAN  = 2'd2;  // framebuffer reads being issued
    localparam logic [1:0] ST_FLUSH = 2'd3;  // draining the last words

    // Default geometry
    localparam int ADDR_W_DEF   = 13;
    localparam int FB_WORDS_DEF = 512;
    localparam int TIMEOUT_DEF  = 4095;

    // Datapath widths
    localparam int DATA_W     = 16;
    localparam int PIX_ADDR_W = 9;
    localparam int SCAN_W     = 10;  // one extra bit marks the end of the frame
    localparam int WDOG_W     = 12;

    // Accelerator write address windows: each window is selected by one
    // high-order address bit.
    localparam int WIN_REQ_BIT    = 12;
    localparam int WIN_SPRITE_BIT = 11;
    localparam int WIN_CHAR_BIT   = 10;
    localparam int WIN_CTRL_BIT   = 9;

    // One framebuffer word and the index it was read from
    typedef struct packed {
        logic [PIX_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } pixWord_t;

endpackage

// File: rtl/accel_frame_ctrl_scan_skid.sv
// accel_scan_skid
// Two-entry FIFO between the framebuffer read port and the pixel output
// handshake. The writer must never push into a full buffer unless the head
// is popped in the same cycle; the sequencer guarantees this by counting
// reads in flight before issuing.
// Ports:
//   clk_i, reset_i      clock, asynchronous active-low reset
//   pushValid/pushWord  word returned by the framebuffer
//   outReady            downstream accepts the head word this cycle
//   outValid/outWord    head word presented downstream
//   count               number of stored entries (0..2)
module accel_scan_skid
    import accel_frame_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       pushValid,
    input  pixWord_t   pushWord,
    input  logic       outReady,
    output logic       outValid,
    output pixWord_t   outWord,
    output logic [1:0] count
);

    pixWord_t   headReg, headNext;
    pixWord_t   tailReg, tailNext;
    logic [1:0] countReg, countNext;
    logic       pop;

    assign outValid = (countReg != 2'd0);
    assign outWord  = headReg;
    assign count    = countReg;
    assign pop      = outValid & outReady;

    always_comb begin
        headNext  = headReg;
        tailNext  = tailReg;
        countNext = countReg + 2'(pushValid) - 2'(pop);
        case (countReg)
            2'd0: begin
                if (pushValid) headNext = pushWord;
            end
            2'd1: begin
                // A push either refills the head being popped or queues behind it
                if (pop) begin
                    if (pushValid) headNext = pushWord;
                end else if (pushValid) begin
                    tailNext = pushWord;
                end
            end
            default: begin
                if (pop) begin
                    headNext = tailReg;
                    if (pushValid) tailNext = pushWord;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            headReg  <= '0;
            tailReg  <= '0;
            countReg <= 2'd0;
        end else begin
            headReg  <= headNext;
            tailReg  <= tailNext;
            countReg <= countNext;
        end
    end

endmodule

// File: rtl/accel_frame_ctrl.sv
// accel_frame_ctrl
// Frame-level sequencer for the sprite/text accelerator. Between frames the
// CPU drives the accelerator port directly; on a frame tick the accelerator
// is given the framebuffer (ext=0) until it signals completion or the
// watchdog expires, then the framebuffer is read out word by word and
// streamed to the display serializer through a 2-entry skid buffer.
// Ports:
//   clk_i, reset_i                   clock, asynchronous active-low reset
//   frame_i                          one-cycle frame tick
//   cpu_waddr_i/cpu_data_i/cpu_write_i/cpu_raddr_i  CPU access
//   cpu_stall_o                      CPU must hold its access
//   accel_ext_o                      1 = accelerator under external control
//   accel_waddr_o/accel_data_o/accel_write_o/accel_raddr_o  accelerator port
//   accel_data_i                     framebuffer read data (1-cycle latency)
//   accel_done_i                     accelerator completion pulse
//   pix_data_o/pix_addr_o/pix_valid_o/pix_ready_i  scanout stream
//   frame_done_o, frame_drop_o       one-cycle status pulses
//   timeout_o                        sticky draw-timeout flag
module accel_frame_ctrl
    import accel_frame_ctrl_pkg::*;
#(
    parameter int ADDR_W_p   = ADDR_W_DEF,
    parameter int FB_WORDS_p = FB_WORDS_DEF,
    parameter int TIMEOUT_p  = TIMEOUT_DEF
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  frame_i,
    input  logic [ADDR_W_p-1:0]   cpu_waddr_i,
    input  logic [DATA_W-1:0]     cpu_data_i,
    input  logic                  cpu_write_i,
    input  logic [PIX_ADDR_W-1:0] cpu_raddr_i,
    output logic                  cpu_stall_o,
    output logic                  accel_ext_o,
    output logic [ADDR_W_p-1:0]   accel_waddr_o,
    output logic [DATA_W-1:0]     accel_data_o,
    output logic                  accel_write_o,
    output logic [PIX_ADDR_W-1:0] accel_raddr_o,
    input  logic [DATA_W-1:0]     accel_data_i,
    input  logic                  accel_done_i,
    output logic [DATA_W-1:0]     pix_data_o,
    output logic [PIX_ADDR_W-1:0] pix_addr_o,
    output logic                  pix_valid_o,
    input  logic                  pix_ready_i,
    output logic                  frame_done_o,
    output logic                  frame_drop_o,
    output logic                  timeout_o
);

    // The watchdog reaches TIMEOUT_p on the edge that leaves DRAW
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_p - 1);
    localparam logic [SCAN_W-1:0] SCAN_END  = SCAN_W'(FB_WORDS_p);

    logic [1:0]            stateReg, stateNext;
    logic [WDOG_W-1:0]     wdogReg;
    logic [SCAN_W-1:0]     scanReg, scanNext;
    logic                  inflightReg;
    logic [PIX_ADDR_W-1:0] inflightAddrReg;
    logic                  timeoutReg, frameDoneReg, frameDropReg;

    logic                  issue, expire, drained, pop;
    logic [2:0]            occupancy;
    logic [1:0]            skidCount;
    pixWord_t              skidIn, skidOut;

    assign pop      = pix_valid_o & pix_ready_i;
    assign scanNext = scanReg + SCAN_W'(1);

    // Entries held plus the read already in flight, crediting the word that
    // leaves this cycle so a steady stream sustains one read per cycle.
    assign occupancy = {1'b0, skidCount} + {2'b00, inflightReg} - {2'b00, pop};

    always_comb begin
        stateNext = stateReg;
        issue     = 1'b0;
        expire    = 1'b0;
        drained   = ~inflightReg &
                    ((skidCount == 2'd0) || ((skidCount == 2'd1) && pop));
        case (stateReg)
            ST_IDLE: begin
                if (frame_i) stateNext = ST_DRAW;
            end
            ST_DRAW: begin
                // Completion beats an expiry on the same edge
                if (accel_done_i) begin
                    stateNext = ST_SCAN;
                end else if (wdogReg == WDOG_LAST) begin
                    expire    = 1'b1;
                    stateNext = ST_SCAN;
                end
            end
            ST_SCAN: begin
                issue = (occupancy < 3'd2);
                if (issue && (scanNext == SCAN_END)) stateNext = ST_FLUSH;
            end
            default: begin
                if (drained) stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stateReg        <= ST_IDLE;
            wdogReg         <= '0;
            scanReg         <= '0;
            inflightReg     <= 1'b0;
            inflightAddrReg <= '0;
            timeoutReg      <= 1'b0;
            frameDoneReg    <= 1'b0;
            frameDropReg    <= 1'b0;
        end else begin
            stateReg        <= stateNext;
            wdogReg         <= (stateReg == ST_DRAW) ? wdogReg + WDOG_W'(1) : '0;
            if (stateReg != ST_SCAN) scanReg <= '0;
            else if (issue)          scanReg <= scanNext;
            inflightReg     <= issue;
            inflightAddrReg <= scanReg[PIX_ADDR_W-1:0];
            timeoutReg      <= timeoutReg | expire;
            frameDoneReg    <= (stateReg == ST_FLUSH) && drained;
            frameDropReg    <= frame_i && (stateReg != ST_IDLE);
        end
    end

    assign skidIn.addr = inflightAddrReg;
    assign skidIn.data = accel_data_i;

    accel_scan_skid u_skid (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .pushValid (inflightReg),
        .pushWord  (skidIn),
        .outReady  (pix_ready_i),
        .outValid  (pix_valid_o),
        .outWord   (skidOut),
        .count     (skidCount)
    );

    // CPU port passes straight through in IDLE; writes are blocked otherwise
    assign accel_ext_o   = (stateReg != ST_DRAW);
    assign cpu_stall_o   = (stateReg != ST_IDLE);
    assign accel_waddr_o = cpu_waddr_i;
    assign accel_data_o  = cpu_data_i;
    assign accel_write_o = (stateReg == ST_IDLE) & cpu_write_i;
    assign accel_raddr_o = (stateReg == ST_IDLE) ? cpu_raddr_i
                                                 : scanReg[PIX_ADDR_W-1:0];

    assign pix_data_o    = skidOut.data;
    assign pix_addr_o    = skidOut.addr;
    assign frame_done_o  = frameDoneReg;
    assign frame_drop_o  = frameDropReg;
    assign timeout_o     = timeoutReg;

endmodule

// File: tb/tb_accel_frame_ctrl.sv
// tb_accel_frame_ctrl
// Scenario tasks drive the frame sequencer; a framebuffer model answers
// reads with a per-frame pattern and a scoreboard queue holds the expected
// scanout words, popped as the DUT hands them over.
module tb_accel_frame_ctrl;

    localparam int ADDR_W   = 13;
    localparam int FB_WORDS = 512;
    localparam int TIMEOUT  = 4095;

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b1;
    logic              frame_i = 1'b0;
    logic [ADDR_W-1:0] cpu_waddr_i = '0;
    logic [15:0]       cpu_data_i = '0;
    logic              cpu_write_i = 1'b0;
    logic [8:0]        cpu_raddr_i = '0;
    logic              cpu_stall_o;
    logic              accel_ext_o;
    logic [ADDR_W-1:0] accel_waddr_o;
    logic [15:0]       accel_data_o;
    logic              accel_write_o;
    logic [8:0]        accel_raddr_o;
    logic [15:0]       accel_data_i = '0;
    logic              accel_done_i = 1'b0;
    logic [15:0]       pix_data_o;
    logic [8:0]        pix_addr_o;
    logic              pix_valid_o;
    logic              pix_ready_i = 1'b1;
    logic              frame_done_o;
    logic              frame_drop_o;
    logic              timeout_o;

    always #5 clk_i = ~clk_i;

    accel_frame_ctrl #(
        .ADDR_W_p   (ADDR_W),
        .FB_WORDS_p (FB_WORDS),
        .TIMEOUT_p  (TIMEOUT)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .frame_i       (frame_i),
        .cpu_waddr_i   (cpu_waddr_i),
        .cpu_data_i    (cpu_data_i),
        .cpu_write_i   (cpu_write_i),
        .cpu_raddr_i   (cpu_raddr_i),
        .cpu_stall_o   (cpu_stall_o),
        .accel_ext_o   (accel_ext_o),
        .accel_waddr_o (accel_waddr_o),
        .accel_data_o  (accel_data_o),
        .accel_write_o (accel_write_o),
        .accel_raddr_o (accel_raddr_o),
        .accel_data_i  (accel_data_i),
        .accel_done_i  (accel_done_i),
        .pix_data_o    (pix_data_o),
        .pix_addr_o    (pix_addr_o),
        .pix_valid_o   (pix_valid_o),
        .pix_ready_i   (pix_ready_i),
        .frame_done_o  (frame_done_o),
        .frame_drop_o  (frame_drop_o),
        .timeout_o     (timeout_o)
    );

    int          vecCnt = 0;
    int          errCnt = 0;
    int          popCnt = 0;
    int          doneCnt = 0;
    int          extLowCnt = 0;
    int          frameNo = 0;
    bit          expTimeout = 1'b0;
    logic [15:0] seed = 16'h1234;
    logic [24:0] sbQ[$];

    function automatic logic [15:0] pattern(input logic [8:0] a, input logic [15:0] s);
        logic [31:0] p;
        p = {23'd0, a} * 32'd40503;
        return p[15:0] ^ s;
    endfunction

    // Framebuffer model: registered read, one cycle of latency
    always @(posedge clk_i) accel_data_i <= pattern(accel_raddr_o, seed);

    // Scanout monitor and scoreboard
    always @(negedge clk_i) begin
        logic [24:0] exp;
        if (accel_ext_o === 1'b0) extLowCnt++;
        if (frame_done_o === 1'b1) doneCnt++;
        if (reset_i === 1'b1 && pix_valid_o === 1'b1 && pix_ready_i === 1'b1) begin
            vecCnt++;
            popCnt++;
            if (sbQ.size() == 0) begin
                errCnt++;
                $display("FAIL scan_word: got addr=%0d data=%h, required no word", pix_addr_o, pix_data_o);
            end else begin
                exp = sbQ.pop_front();
                if ({pix_addr_o, pix_data_o} !== exp) begin
                    errCnt++;
                    $display("FAIL scan_word: got addr=%0d data=%h, required addr=%0d data=%h",
                             pix_addr_o, pix_data_o, exp[24:16], exp[15:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic [30:0] obs;
        #2 reset_i = 1'b0;
        #1;
        obs = {accel_ext_o, cpu_stall_o, pix_valid_o, frame_done_o, frame_drop_o, timeout_o, pix_addr_o, pix_data_o};
        vecCnt++;
        if (obs !== {1'b1, 5'b0, 9'd0, 16'd0}) begin
            errCnt++;
            $display("FAIL reset_values: got %h, required %h", obs, {1'b1, 5'b0, 9'd0, 16'd0});
        end
        tick();
        tick();
        reset_i = 1'b1;
        tick();
        $display("reset: outputs %h", obs);
    endtask

    task automatic test_cpu_write();
        logic [40:0] obs;
        cpu_waddr_i = 13'h0205;
        cpu_data_i  = 16'hBEEF;
        cpu_raddr_i = 9'h1A5;
        cpu_write_i = 1'b1;
        #1;
        obs = {accel_write_o, accel_waddr_o, accel_data_o, cpu_stall_o, accel_ext_o, accel_raddr_o};
        vecCnt++;
        if (obs !== {1'b1, 13'h0205, 16'hBEEF, 1'b0, 1'b1, 9'h1A5}) begin
            errCnt++;
            $display("FAIL cpu_write: got %h, required %h", obs, {1'b1, 13'h0205, 16'hBEEF, 1'b0, 1'b1, 9'h1A5});
        end
        tick();
        cpu_write_i = 1'b0;
        // Completion pulse while idle must not start anything
        accel_done_i = 1'b1;
        tick();
        accel_done_i = 1'b0;
        tick();
        vecCnt++;
        if (cpu_stall_o !== 1'b0 || accel_ext_o !== 1'b1) begin
            errCnt++;
            $display("FAIL done_in_idle: got stall=%b ext=%b, required stall=0 ext=1", cpu_stall_o, accel_ext_o);
        end
        $display("cpu_write: addr=0205 data=BEEF write=%b", obs[40]);
    endtask

    // Frame tick from IDLE; optionally with a simultaneous CPU write
    task automatic start_frame(input bit withWrite);
        frameNo++;
        seed = 16'($urandom);
        for (int a = 0; a < FB_WORDS; a++) sbQ.push_back({9'(a), pattern(9'(a), seed)});
        popCnt  = 0;
        doneCnt = 0;
        frame_i = 1'b1;
        if (withWrite) begin
            cpu_waddr_i = 13'h1F00;
            cpu_data_i  = 16'h0123;
            cpu_write_i = 1'b1;
            #1;
            vecCnt++;
            if (accel_write_o !== 1'b1 || cpu_stall_o !== 1'b0) begin
                errCnt++;
                $display("FAIL frame_with_write: got write=%b stall=%b, required write=1 stall=0", accel_write_o, cpu_stall_o);
            end
        end
        @(posedge clk_i);
        extLowCnt = 0;
        #1;
        frame_i     = 1'b0;
        cpu_write_i = 1'b0;
        vecCnt++;
        if (cpu_stall_o !== 1'b1 || accel_ext_o !== 1'b0 || accel_write_o !== 1'b0) begin
            errCnt++;
            $display("FAIL frame_start: got stall=%b ext=%b write=%b, required 1 0 0", cpu_stall_o, accel_ext_o, accel_write_o);
        end
    endtask

    // Stay in DRAW for d cycles, ending with a completion pulse if giveDone
    task automatic run_draw(input int d, input bit giveDone);
        for (int i = 1; i < d; i++) begin
            if (i == 5) begin
                cpu_write_i = 1'b1;
                #1;
                vecCnt++;
                if (accel_write_o !== 1'b0 || cpu_stall_o !== 1'b1) begin
                    errCnt++;
                    $display("FAIL draw_write_block: got write=%b stall=%b, required write=0 stall=1", accel_write_o, cpu_stall_o);
                end
                cpu_write_i = 1'b0;
            end
            tick();
        end
        vecCnt++;
        if (timeout_o !== expTimeout) begin
            errCnt++;
            $display("FAIL timeout_early: got %b, required %b", timeout_o, expTimeout);
        end
        if (giveDone) accel_done_i = 1'b1;
        tick();
        accel_done_i = 1'b0;
        if (!giveDone) expTimeout = 1'b1;
        vecCnt++;
        if (timeout_o !== expTimeout || accel_ext_o !== 1'b1 || accel_raddr_o !== 9'd0 || extLowCnt != d) begin
            errCnt++;
            $display("FAIL draw_exit: got timeout=%b ext=%b raddr=%0d ext_low=%0d, required %b 1 0 %0d",
                     timeout_o, accel_ext_o, accel_raddr_o, extLowCnt, expTimeout, d);
        end
    endtask

    // Called right after SCAN entry; waits for frame_done and checks the frame
    task automatic run_scan(input bit randReady, input bit dropTest);
        int cycles = 0;
        if (!randReady) begin
            tick();
            vecCnt++;
            if (pix_valid_o !== 1'b0) begin
                errCnt++;
                $display("FAIL first_valid_early: got valid=%b, required 0", pix_valid_o);
            end
            tick();
            vecCnt++;
            if (pix_valid_o !== 1'b1 || pix_addr_o !== 9'd0 || pix_data_o !== pattern(9'd0, seed)) begin
                errCnt++;
                $display("FAIL first_valid: got valid=%b addr=%0d data=%h, required 1 0 %h",
                         pix_valid_o, pix_addr_o, pix_data_o, pattern(9'd0, seed));
            end
            cycles = 2;
        end
        while (frame_done_o !== 1'b1 && cycles < 4 * FB_WORDS + 100) begin
            tick();
            cycles++;
            if (randReady) pix_ready_i = 1'($urandom_range(0, 1));
            if (dropTest && cycles == 50) begin
                frame_i = 1'b1;
                tick();
                cycles++;
                frame_i = 1'b0;
                vecCnt++;
                if (frame_drop_o !== 1'b1 || cpu_stall_o !== 1'b1 || accel_ext_o !== 1'b1) begin
                    errCnt++;
                    $display("FAIL frame_drop: got drop=%b stall=%b ext=%b, required 1 1 1", frame_drop_o, cpu_stall_o, accel_ext_o);
                end
            end
        end
        pix_ready_i = 1'b1;
        vecCnt++;
        if (frame_done_o !== 1'b1) begin
            errCnt++;
            $display("FAIL frame_done_wait: got no frame_done in %0d cycles, required a pulse", cycles);
        end
        if (!randReady) begin
            vecCnt++;
            if (cycles != FB_WORDS + 2) begin
                errCnt++;
                $display("FAIL scan_latency: got %0d cycles, required %0d", cycles, FB_WORDS + 2);
            end
        end
        tick();
        tick();
        tick();
        vecCnt++;
        if (doneCnt != 1 || sbQ.size() != 0 || popCnt != FB_WORDS || cpu_stall_o !== 1'b0 ||
            accel_ext_o !== 1'b1 || timeout_o !== expTimeout) begin
            errCnt++;
            $display("FAIL frame_end: got done=%0d left=%0d words=%0d stall=%b ext=%b timeout=%b, required 1 0 %0d 0 1 %b",
                     doneCnt, sbQ.size(), popCnt, cpu_stall_o, accel_ext_o, timeout_o, FB_WORDS, expTimeout);
        end
        $display("frame %0d: scan cycles=%0d words=%0d timeout=%b", frameNo, cycles, popCnt, timeout_o);
    endtask

    task automatic test_normal_frame();
        start_frame(1'b1);
        run_draw(40, 1'b1);
        run_scan(1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        tick();
        start_frame(1'b0);
        run_draw(40, 1'b1);
        run_scan(1'b1, 1'b1);
    endtask

    task automatic test_timeout();
        tick();
        start_frame(1'b0);
        run_draw(TIMEOUT, 1'b0);
        run_scan(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_scan();
        logic [30:0] obs;
        bit reached = 1'b0;
        tick();
        start_frame(1'b0);
        run_draw(40, 1'b1);
        for (int k = 0; k < 600 && !reached; k++) begin
            @(negedge clk_i);
            #1;
            if (popCnt >= 100) reached = 1'b1;
        end
        vecCnt++;
        if (!reached) begin
            errCnt++;
            $display("FAIL reset_wait: got %0d words, required 100", popCnt);
        end
        #1 reset_i = 1'b0;
        expTimeout = 1'b0;
        #1;
        obs = {accel_ext_o, cpu_stall_o, pix_valid_o, frame_done_o, frame_drop_o, timeout_o, pix_addr_o, pix_data_o};
        vecCnt++;
        if (obs !== {1'b1, 5'b0, 9'd0, 16'd0}) begin
            errCnt++;
            $display("FAIL reset_async: got %h, required %h", obs, {1'b1, 5'b0, 9'd0, 16'd0});
        end
        sbQ.delete();
        tick();
        tick();
        reset_i = 1'b1;
        tick();
        $display("reset mid-scan after %0d words: outputs %h", popCnt, obs);
        start_frame(1'b0);
        run_draw(40, 1'b1);
        run_scan(1'b0, 1'b0);
    endtask

    task automatic test_done_at_expiry();
        tick();
        start_frame(1'b0);
        run_draw(TIMEOUT, 1'b1);
        run_scan(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_normal_frame();
        test_back_to_back();
        test_timeout();
        test_reset_mid_scan();
        test_done_at_expiry();
        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
